bcd_display_feeder: RTL and testbench
=====================================

// Module: bcd_display_feeder
// PURPOSE
//  Converts a binary value from the CPU store path into packed BCD (or passes raw hex through).
//  Issues a one-cycle write strobe to the downstream 4-digit seven-segment driver
//  (16-bit data + write-enable input).
//  Uses a sequential shift-add-3 (double dabble) converter: one bit per clock.
//  Out-of-range values are flagged and shown as an error pattern.
// PARAMETERS
//  BIN_WIDTH  14  binary operand width used in BCD mode; must be <= 4*DIGITS
//  DIGITS     4   BCD digits produced; o_data width = 4*DIGITS
// PORTS
//  clk         in   1          single clock, all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  i_data      in   4*DIGITS   operand; BCD mode uses [BIN_WIDTH-1:0], upper bits ignored
//  i_hex_mode  in   1          1: pass i_data through unchanged; 0: convert to BCD
//  i_valid     in   1          request; accepted on an edge where i_valid && o_ready
//  o_ready     out  1          high when IDLE and rst low
//  o_data      out  4*DIGITS   registered result; holds its value between strobes
//  o_we        out  1          one-cycle strobe: o_data is new this cycle
//  o_overflow  out  1          registered with each o_we; 1 = last BCD operand > 10^DIGITS-1
// BEHAVIOUR
//  Reset: state=IDLE, o_data=0, o_we=0, o_overflow=0, o_ready=0 while rst is high.
//  FSM states:
//   - IDLE: o_ready=1.
//     - Accept with hex=1: o_data<=i_data, o_overflow<=0, o_we<=1 at the accepting edge; stay IDLE.
//     - Accept with hex=0: latch operand into the shift register, clear BCD accumulator,
//       cnt<=0, go to SHIFT.
//   - SHIFT: o_ready=0.
//     - Each edge: add 3 to every BCD digit >= 5, then shift {bcd,bin} left 1; cnt++.
//     - On the edge completing shift BIN_WIDTH: load o_data, set o_we<=1, return to IDLE.
//  Latency: hex mode, o_we high in the cycle after the accepting edge.
//   BCD mode, o_we high BIN_WIDTH edges after the accepting edge (14 by default).
//  o_we is high for exactly 1 cycle per accepted request; it is never asserted otherwise.
//  Back-to-back: o_ready=1 during the o_we cycle, so a new request may be accepted there.
//  i_valid while busy is ignored (not queued); the source holds it until o_ready.
//  Overflow: the compare operand > 10^DIGITS-1 is evaluated and registered at accept.
//   - The full conversion latency still applies.
//   - Result is o_data = {DIGITS{4'hE}} with o_overflow=1.
//  Width: the accumulator is 4*DIGITS bits. Carries out of the top digit are discarded;
//   this happens only on overflow, where the result is replaced anyway.
//  Reset mid-SHIFT aborts the conversion: no o_we, o_data keeps its reset value 0.
//  Changes to i_data or i_hex_mode after accept have no effect on the conversion in flight.
// STRUCTURE
//  Shared header display_defs.vh holds:
//   - FSM state encoding (IDLE, SHIFT)
//   - DISP_ERR_DIGIT = 4'hE
//   - localparam function for 10^DIGITS-1
//  Sub-module dabble_step (combinational): one add-3-and-shift iteration over DIGITS digits.
//   Input: {bcd, msb}. Output: next bcd.
//  The top level owns the FSM, the shift and accumulator registers, cnt, and the output registers.
// TESTING
//  1. BCD: i_data=0x04D2 (1234), accept at edge E0 -> o_we only in cycle after E14, o_data=16'h1234, o_overflow=0.
//  2. Bounds: 0 -> 16'h0000; 9999 -> 16'h9999; 10000 and 16383 -> 16'hEEEE with o_overflow=1.
//  3. Hex: i_hex_mode=1, i_data=16'hBEEF -> o_data=16'hBEEF, o_we 1 cycle after accept; 3 consecutive accepts -> 3 consecutive strobes.
//  4. Busy: i_valid held high with new data during SHIFT -> ignored; accepted in the o_we cycle; second result 14 edges later.
//  5. Reset at 5th shift -> no o_we ever, o_data=0, o_ready=1 the first cycle after rst drops.
//  6. Random 0..16383 x1000 vs reference model -> exact o_data/o_overflow; o_we count == accept count.

Source files
------------

// File: rtl/bcd_display_feeder_pkg.sv
// Shared definitions for the BCD display feeder: FSM encoding,
// the error digit, and a helper for the largest value DIGITS can show.
package bcd_display_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] DISP_ERR_DIGIT = 4'hE;

  // Largest decimal value representable in 'digits' BCD digits (10^digits - 1).
  function automatic int unsigned bcd_max(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_display_feeder_dabble_step.sv
// One double-dabble iteration: add 3 to each BCD digit >= 5, then shift the
// accumulator left by one, bringing in the next binary bit at the bottom.
module bcd_display_feeder_dabble_step #(
  parameter int unsigned DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                msb,
  output logic [4*DIGITS-1:0] bcd_next
);

  logic [4*DIGITS-1:0] adj;

  // Per-digit add-3 correction followed by the one-bit shift.
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    // The carry out of the top digit is dropped; it only occurs on overflow.
    bcd_next = {adj[4*DIGITS-2:0], msb};
  end

endmodule

// File: rtl/bcd_display_feeder.sv
// Feeds a 4-digit seven-segment driver: converts a binary operand to packed
// BCD one bit per clock (or passes raw hex through) and issues a one-cycle
// write strobe with the result.
module bcd_display_feeder
  import bcd_display_feeder_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] i_data,
  input  logic                i_hex_mode,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [4*DIGITS-1:0] o_data,
  output logic                o_we,
  output logic                o_overflow
);

  localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(bcd_max(DIGITS));

  state_t               state, state_next;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [4*DIGITS-1:0]  bcd_q, bcd_next;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_q;
  logic                 accept, last_shift, ovf_in;

  assign accept     = i_valid && o_ready;
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(BIN_WIDTH - 1));
  assign ovf_in     = 32'(i_data[BIN_WIDTH-1:0]) > MAX_VAL;

  bcd_display_feeder_dabble_step #(
    .DIGITS(DIGITS)
  ) u_step (
    .bcd     (bcd_q),
    .msb     (bin_q[BIN_WIDTH-1]),
    .bcd_next(bcd_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: BCD requests enter SHIFT, the last shift returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !i_hex_mode) state_next = SHIFT;
      SHIFT:   if (last_shift)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready only when idle and out of reset.
  always_comb begin
    o_ready = (state == IDLE) && !rst;
  end

  // Datapath: operand capture, shift/accumulate, and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt        <= '0;
      ovf_q      <= 1'b0;
      o_data     <= '0;
      o_we       <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (i_hex_mode) begin
              o_data     <= i_data;
              o_overflow <= 1'b0;
              o_we       <= 1'b1;
            end else begin
              bin_q <= i_data[BIN_WIDTH-1:0];
              bcd_q <= '0;
              cnt   <= '0;
              ovf_q <= ovf_in;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_next;
          bin_q <= bin_q << 1;
          cnt   <= cnt + 1'b1;
          if (last_shift) begin
            o_data     <= ovf_q ? {DIGITS{DISP_ERR_DIGIT}} : bcd_next;
            o_overflow <= ovf_q;
            o_we       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Directed and randomised checks for bcd_display_feeder.
module tb_bcd_display_feeder;

  localparam int unsigned BIN_WIDTH = 14;
  localparam int unsigned DIGITS    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_data;
  logic        i_hex_mode;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_we;
  logic        o_overflow;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_accept  = 0;
  int n_strobe  = 0;

  bcd_display_feeder #(
    .BIN_WIDTH(BIN_WIDTH),
    .DIGITS   (DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_hex_mode(i_hex_mode),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_we      (o_we),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_we === 1'b1) n_strobe++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by division, error pattern above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'hEEEE;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Present one request for exactly one edge.
  task automatic start(input logic [15:0] d, input logic hex);
    i_data     = d;
    i_hex_mode = hex;
    i_valid    = 1'b1;
    tick();
    i_valid    = 1'b0;
    n_accept++;
  endtask

  // Called just after the accepting edge; expects the strobe exactly BIN_WIDTH edges later.
  task automatic wait_result(input string tag, input logic [15:0] exp_d, input logic exp_o);
    int early;
    early = 0;
    repeat (BIN_WIDTH - 1) begin
      tick();
      if (o_we !== 1'b0) early++;
    end
    check({tag, "_early_we"}, early, 0);
    tick();
    check({tag, "_we"}, o_we, 1);
    check({tag, "_data"}, o_data, exp_d);
    check({tag, "_ovf"}, o_overflow, exp_o);
    check({tag, "_ready"}, o_ready, 1);
  endtask

  task automatic do_bcd(input string tag, input int v);
    start(16'(v), 1'b0);
    check({tag, "_busy"}, o_ready, 0);
    wait_result(tag, ref_bcd(v), v > 9999);
  endtask

  initial begin
    int early;
    int v;
    rst = 1'b1; i_data = '0; i_hex_mode = 1'b0; i_valid = 1'b0;
    repeat (3) tick();
    check("rst_data", o_data, 0);
    check("rst_we", o_we, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_ready", o_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", o_ready, 1);

    // 1234 with exact latency, then bounds.
    do_bcd("bcd1234", 1234);
    check("bcd1234_lit", o_data, 16'h1234);
    tick();
    check("bcd1234_we_drop", o_we, 0);
    check("bcd1234_hold", o_data, 16'h1234);
    do_bcd("bcd0", 0);
    check("bcd0_lit", o_data, 16'h0000);
    do_bcd("bcd9999", 9999);
    check("bcd9999_lit", o_data, 16'h9999);
    do_bcd("bcd10000", 10000);
    check("bcd10000_lit", o_data, 16'hEEEE);
    do_bcd("bcd16383", 16383);
    check("bcd16383_ovf_lit", o_overflow, 1);

    // Hex pass-through, then three back-to-back accepts.
    tick();
    start(16'hBEEF, 1'b1);
    check("hex_we", o_we, 1);
    check("hex_data", o_data, 16'hBEEF);
    check("hex_ovf", o_overflow, 0);
    tick();
    check("hex_we_drop", o_we, 0);
    i_hex_mode = 1'b1; i_valid = 1'b1;
    i_data = 16'h1111; tick(); n_accept++;
    check("hex3_a", {o_we, o_data}, {1'b1, 16'h1111});
    i_data = 16'hA5C3; tick(); n_accept++;
    check("hex3_b", {o_we, o_data}, {1'b1, 16'hA5C3});
    i_data = 16'hFFFF; tick(); n_accept++;
    check("hex3_c", {o_we, o_data}, {1'b1, 16'hFFFF});
    i_valid = 1'b0;
    tick();
    check("hex3_drop", o_we, 0);

    // Busy: valid held with new data during SHIFT is ignored until the strobe cycle.
    start(16'd1234, 1'b0);
    i_data = 16'd5678; i_hex_mode = 1'b0; i_valid = 1'b1;
    wait_result("busy_first", 16'h1234, 1'b0);
    tick(); n_accept++;
    i_valid = 1'b0;
    check("busy_second_accepted", o_ready, 0);
    check("busy_we_drop", o_we, 0);
    wait_result("busy_second", 16'h5678, 1'b0);

    // Reset during the 5th shift aborts the conversion.
    rst = 1'b1; tick(); rst = 1'b0; #1;
    start(16'd4321, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_ready_in_rst", o_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_ready", o_ready, 1);
    early = 0;
    repeat (20) begin
      tick();
      if (o_we !== 1'b0) early++;
    end
    check("abort_no_we", early, 0);
    check("abort_data", o_data, 0);
    n_accept--;

    // Random operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      v = int'($urandom_range(0, 16383));
      start(16'(v), 1'b0);
      wait_result("rand", ref_bcd(v), v > 9999);
    end
    tick();
    check("strobe_count", n_strobe, n_accept);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
